// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: fault codes, funct3/oplen encodings,
// the request FIFO entry and the FSM state encoding.
package lsu_pkg;

  localparam int LSU_TAG_W = 5;

  typedef enum logic [1:0] {
    FAULT_NONE       = 2'd0,
    FAULT_MISALIGNED = 2'd1,
    FAULT_TIMEOUT    = 2'd2,
    FAULT_ILLEGAL    = 2'd3
  } fault_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] OPLEN_B = 2'd0;
  localparam logic [1:0] OPLEN_H = 2'd1;
  localparam logic [1:0] OPLEN_W = 2'd3;

  typedef struct packed {
    logic                 we;
    logic [1:0]           oplen;
    logic                 is_unsigned;
    logic [31:0]          addr;
    logic [31:0]          wdata;
    logic [LSU_TAG_W-1:0] tag;
    fault_e               fault;
  } lsu_entry_t;

  typedef logic [1:0] state_e;
  localparam state_e IDLE  = 2'd0;
  localparam state_e ISSUE = 2'd1;
  localparam state_e GAP   = 2'd2;

  // Illegal encodings win over misalignment so a bad opcode is never
  // reported as an alignment problem.
  function automatic lsu_entry_t lsu_decode(input logic                 we,
                                            input logic [2:0]           funct3,
                                            input logic [31:0]          addr,
                                            input logic [31:0]          wdata,
                                            input logic [LSU_TAG_W-1:0] tag);
    lsu_entry_t e;
    logic       illegal;
    logic       misaligned;
    e.we          = we;
    e.addr        = addr;
    e.wdata       = wdata;
    e.tag         = tag;
    e.is_unsigned = funct3[2];
    case (funct3)
      F3_B, F3_BU: e.oplen = OPLEN_B;
      F3_H, F3_HU: e.oplen = OPLEN_H;
      default:     e.oplen = OPLEN_W;
    endcase
    illegal    = !(funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU}) || (we && funct3[2]);
    misaligned = ((e.oplen == OPLEN_H) && addr[0]) ||
                 ((e.oplen == OPLEN_W) && (addr[1:0] != 2'b00));
    if (illegal)         e.fault = FAULT_ILLEGAL;
    else if (misaligned) e.fault = FAULT_MISALIGNED;
    else                 e.fault = FAULT_NONE;
    return e;
  endfunction

endpackage

// File: rtl/lsu_req_fifo.sv
// In-order request FIFO of decoded load/store entries; head is the oldest entry.
module lsu_req_fifo
  import lsu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  lsu_entry_t din,
  output lsu_entry_t head,
  output logic       full,
  output logic       empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  lsu_entry_t     mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    count;
  logic           push_ok;
  logic           pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// CPU-side load/store initiator: queues ops, filters faulted ones, runs the
// enable/valid data handshake with a watchdog and retires responses in order.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int FIFO_DEPTH     = 2,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TAG_W          = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cpu_valid,
  output logic             cpu_ready,
  input  logic             cpu_we,
  input  logic [2:0]       cpu_funct3,
  input  logic [31:0]      cpu_addr,
  input  logic [31:0]      cpu_wdata,
  input  logic [TAG_W-1:0] cpu_tag,
  output logic             rsp_valid,
  output logic [TAG_W-1:0] rsp_tag,
  output logic [31:0]      rsp_data,
  output logic             rsp_is_store,
  output logic [1:0]       rsp_fault,
  output logic             data_enable,
  input  logic             data_valid,
  output logic [1:0]       data_oplen,
  output logic             data_unsigned,
  output logic [31:0]      data_addr,
  output logic [31:0]      data_wdata,
  output logic             data_we,
  input  logic [31:0]      data_result,
  output logic [1:0]       dbg_state
);

  // Handshake: an op is accepted on cpu_valid && cpu_ready; a memory access
  // holds data_enable and every data_* field steady up to and including the
  // cycle data_valid is sampled, then drops enable for at least one cycle.

  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

  state_e        state;
  logic [TW-1:0] tcnt;
  lsu_entry_t    push_entry;
  lsu_entry_t    head;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  logic          head_fault;
  logic          timeout;
  logic          done;

  assign cpu_ready  = !full && !rst;
  assign push       = cpu_valid && cpu_ready;
  assign push_entry = lsu_decode(cpu_we, cpu_funct3, cpu_addr, cpu_wdata, LSU_TAG_W'(cpu_tag));
  assign head_fault = !empty && (head.fault != FAULT_NONE);
  assign timeout    = (tcnt == TW'(TIMEOUT_CYCLES - 1));
  assign done       = (state == ISSUE) && (data_valid || timeout);
  assign pop        = done || ((state != ISSUE) && head_fault);
  assign dbg_state  = state;

  lsu_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (push_entry),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      tcnt          <= '0;
      data_enable   <= 1'b0;
      data_oplen    <= '0;
      data_unsigned <= 1'b0;
      data_addr     <= '0;
      data_wdata    <= '0;
      data_we       <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_tag       <= '0;
      rsp_data      <= '0;
      rsp_is_store  <= 1'b0;
      rsp_fault     <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE, GAP: begin
          tcnt <= '0;
          if (head_fault) begin
            rsp_valid    <= 1'b1;
            rsp_tag      <= TAG_W'(head.tag);
            rsp_data     <= '0;
            rsp_is_store <= head.we;
            rsp_fault    <= head.fault;
            state        <= IDLE;
          end else if (!empty) begin
            data_enable   <= 1'b1;
            data_oplen    <= head.oplen;
            data_unsigned <= head.is_unsigned;
            data_addr     <= head.addr;
            data_wdata    <= head.wdata;
            data_we       <= head.we;
            state         <= ISSUE;
          end else begin
            state <= IDLE;
          end
        end
        ISSUE: begin
          tcnt <= tcnt + 1'b1;
          // A completion landing on the last watchdog cycle still counts as success.
          if (done) begin
            data_enable  <= 1'b0;
            rsp_valid    <= 1'b1;
            rsp_tag      <= TAG_W'(head.tag);
            rsp_data     <= (data_valid && !head.we) ? data_result : 32'd0;
            rsp_is_store <= head.we;
            rsp_fault    <= data_valid ? FAULT_NONE : FAULT_TIMEOUT;
            state        <= GAP;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with an op-level reference model and
// a reactive memory controller model.
module tb_load_store_unit;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_valid = 1'b0;
  logic        cpu_ready;
  logic        cpu_we = 1'b0;
  logic [2:0]  cpu_funct3 = '0;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic [4:0]  cpu_tag = '0;
  logic        rsp_valid;
  logic [4:0]  rsp_tag;
  logic [31:0] rsp_data;
  logic        rsp_is_store;
  logic [1:0]  rsp_fault;
  logic        data_enable;
  logic        data_valid;
  logic [1:0]  data_oplen;
  logic        data_unsigned;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_we;
  logic [31:0] data_result;
  logic [1:0]  dbg_state;

  load_store_unit #(.FIFO_DEPTH(2), .TIMEOUT_CYCLES(TMO), .TAG_W(5)) dut (
    .clk(clk), .rst(rst),
    .cpu_valid(cpu_valid), .cpu_ready(cpu_ready), .cpu_we(cpu_we),
    .cpu_funct3(cpu_funct3), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_tag(cpu_tag),
    .rsp_valid(rsp_valid), .rsp_tag(rsp_tag), .rsp_data(rsp_data),
    .rsp_is_store(rsp_is_store), .rsp_fault(rsp_fault),
    .data_enable(data_enable), .data_valid(data_valid), .data_oplen(data_oplen),
    .data_unsigned(data_unsigned), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_we(data_we), .data_result(data_result), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial forever #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  oplen;
    logic        uns;
    logic        we;
    logic [31:0] result;
    int          lat;
    int          cycles;
  } acc_t;

  logic [39:0] exp_q[$];   // {tag[4:0], is_store, fault[1:0], data[31:0]}
  acc_t        issue_q[$];
  int          gap_q[$];

  int          n_cmp = 0;
  int          n_bad = 0;
  int          ecnt = 0;
  int          low_run = 0;
  int          en_total = 0;
  int          rsp_seen = 0;
  logic        flushing = 1'b0;
  logic        late_valid = 1'b0;
  logic        blocked_seen = 1'b0;
  logic [4:0]  last_tag = '0;
  logic [31:0] last_data = '0;
  logic        last_st = 1'b0;
  logic [1:0]  last_fault = '0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s at %0t", name, $time);
  endfunction

  // Reference model: an accepted op yields one response and, when it is
  // legal and aligned, one memory access of known length.
  function automatic void model_accept(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                       input logic [31:0] wdata, input logic [4:0] tag,
                                       input logic [31:0] result, input int lat);
    logic [31:0] sz;
    logic [1:0]  flt;
    logic [31:0] d;
    acc_t        a;
    sz = 32'd1 << f3[1:0];
    d  = 32'd0;
    if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7 || (we && f3[2])) flt = 2'd3;
    else if ((addr % sz) != 0)                                    flt = 2'd1;
    else                                                          flt = 2'd0;
    if (flt == 2'd0) begin
      a.addr   = addr;
      a.wdata  = wdata;
      a.we     = we;
      a.uns    = f3[2];
      a.oplen  = (sz == 1) ? 2'd0 : (sz == 2) ? 2'd1 : 2'd3;
      a.result = result;
      a.lat    = lat;
      if (lat == 0 || lat > TMO) begin
        a.cycles = TMO;
        flt      = 2'd2;
      end else begin
        a.cycles = lat;
        d        = we ? 32'd0 : result;
      end
      issue_q.push_back(a);
    end
    exp_q.push_back({tag, we, flt, d});
  endfunction

  // ---------------- memory controller model ----------------
  initial begin
    data_valid  = 1'b0;
    data_result = '0;
    forever begin
      @(posedge clk); #1;
      data_valid  = 1'b0;
      data_result = '0;
      if (flushing || rst) begin
        ecnt    = 0;
        low_run = 0;
      end else if (data_enable) begin
        if (ecnt == 0) gap_q.push_back(low_run);
        ecnt++;
        en_total++;
        low_run = 0;
        if (issue_q.size() > 0 && issue_q[0].lat == ecnt) begin
          data_valid  = 1'b1;
          data_result = issue_q[0].result;
        end
      end else begin
        low_run++;
        if (ecnt > 0) begin
          if (issue_q.size() > 0) begin
            check("enable_cycles", ecnt, issue_q[0].cycles);
            void'(issue_q.pop_front());
          end
          ecnt = 0;
          if (late_valid) begin
            data_valid  = 1'b1;
            data_result = 32'hBAD0_BAD0;
          end
        end
      end
    end
  end

  // ---------------- compare process ----------------
  initial forever begin
    @(negedge clk);
    if (!rst && !flushing) begin
      if (rsp_valid) begin
        rsp_seen++;
        last_tag   = rsp_tag;
        last_data  = rsp_data;
        last_st    = rsp_is_store;
        last_fault = rsp_fault;
        if (exp_q.size() == 0) begin
          fail("rsp_unexpected");
        end else begin
          logic [39:0] e;
          e = exp_q.pop_front();
          check("rsp_tag", rsp_tag, e[39:35]);
          check("rsp_is_store", rsp_is_store, e[34]);
          check("rsp_fault", rsp_fault, e[33:32]);
          check("rsp_data", rsp_data, e[31:0]);
        end
      end
      if (data_enable) begin
        if (issue_q.size() == 0) begin
          fail("enable_spurious");
        end else begin
          check("data_addr", data_addr, issue_q[0].addr);
          check("data_oplen", data_oplen, issue_q[0].oplen);
          check("data_unsigned", data_unsigned, issue_q[0].uns);
          check("data_we", data_we, issue_q[0].we);
          if (issue_q[0].we) check("data_wdata", data_wdata, issue_q[0].wdata);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [4:0] tag,
                         input logic [31:0] result, input int lat);
    int   guard;
    logic acc;
    guard      = 0;
    acc        = 1'b0;
    cpu_valid  = 1'b1;
    cpu_we     = we;
    cpu_funct3 = f3;
    cpu_addr   = addr;
    cpu_wdata  = wdata;
    cpu_tag    = tag;
    while (!acc && guard < 100) begin
      @(negedge clk);
      if (cpu_ready) begin
        acc = 1'b1;
        model_accept(we, f3, addr, wdata, tag, result, lat);
      end else begin
        blocked_seen = 1'b1;
      end
      @(posedge clk); #1;
      guard++;
    end
    cpu_valid = 1'b0;
    if (!acc) fail("push_not_accepted");
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while ((exp_q.size() != 0 || issue_q.size() != 0 || data_enable) && g < 300) begin
      @(posedge clk); #1;
      g++;
    end
    if (g >= 300) fail("idle_timeout");
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    fail("global_timeout");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // ---------------- directed tests ----------------
  initial begin
    int en0;
    int rs0;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_cpu_ready", cpu_ready, 0);
    check("reset_enable", data_enable, 0);
    check("reset_rsp_valid", rsp_valid, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_ready", cpu_ready, 1);
    check("post_reset_state", dbg_state, 0);
    check("post_reset_addr", data_addr, 0);
    @(posedge clk); #1;

    // LW with a 3-cycle memory
    en0 = en_total;
    push_op(1'b0, 3'b010, 32'h10, 32'h0, 5'd1, 32'hDEADBEEF, 3);
    wait_idle();
    check("t1_enable_cycles", en_total - en0, 3);
    check("t1_data", last_data, 32'hDEADBEEF);
    check("t1_fault", last_fault, 0);
    check("t1_tag", last_tag, 1);

    // LB, LBU, SW back-to-back
    gap_q.delete();
    blocked_seen = 1'b0;
    push_op(1'b0, 3'b000, 32'h21, 32'h0, 5'd2, 32'hFFFFFF80, 2);
    push_op(1'b0, 3'b100, 32'h21, 32'h0, 5'd3, 32'h00000080, 1);
    push_op(1'b1, 3'b010, 32'h100, 32'h12345678, 5'd4, 32'hCAFEF00D, 1);
    wait_idle();
    check("t2_ready_dropped", blocked_seen, 1);
    check("t2_access_count", gap_q.size(), 3);
    if (gap_q.size() == 3) begin
      check("t2_gap_1", gap_q[1], 1);
      check("t2_gap_2", gap_q[2], 1);
    end
    check("t2_store_flag", last_st, 1);
    check("t2_store_data", last_data, 0);

    // misaligned LH / LW never touch memory
    en0 = en_total;
    rs0 = rsp_seen;
    push_op(1'b0, 3'b001, 32'h3, 32'h0, 5'd5, 32'h0, 1);
    push_op(1'b0, 3'b010, 32'h6, 32'h0, 5'd6, 32'h0, 1);
    wait_idle();
    check("t3_no_enable", en_total - en0, 0);
    check("t3_rsp_count", rsp_seen - rs0, 2);
    check("t3_fault", last_fault, 1);
    check("t3_tag", last_tag, 6);

    // illegal store width, then illegal code on a misaligned address
    en0 = en_total;
    push_op(1'b1, 3'b100, 32'h200, 32'hFF, 5'd7, 32'h0, 1);
    wait_idle();
    check("t4_fault", last_fault, 3);
    check("t4_tag", last_tag, 7);
    push_op(1'b0, 3'b111, 32'h3, 32'h0, 5'd8, 32'h0, 1);
    wait_idle();
    check("t4_precedence", last_fault, 3);
    check("t4_no_enable", en_total - en0, 0);

    // watchdog: never-completing LW, late valid in the gap; then a completion on the last cycle
    late_valid = 1'b1;
    en0 = en_total;
    push_op(1'b0, 3'b010, 32'h400, 32'h0, 5'd9, 32'h0, 0);
    wait_idle();
    check("t5_enable_cycles", en_total - en0, TMO);
    check("t5_fault", last_fault, 2);
    check("t5_data", last_data, 0);
    push_op(1'b0, 3'b010, 32'h404, 32'h0, 5'd10, 32'h0BADF00D, TMO);
    wait_idle();
    check("t5_edge_fault", last_fault, 0);
    check("t5_edge_data", last_data, 32'h0BADF00D);
    late_valid = 1'b0;

    // good op followed by faulted op through the gap, then a normal op
    push_op(1'b0, 3'b010, 32'h20, 32'h0, 5'd11, 32'h11112222, 1);
    push_op(1'b0, 3'b001, 32'h21, 32'h0, 5'd12, 32'h0, 1);
    push_op(1'b0, 3'b100, 32'h22, 32'h0, 5'd13, 32'h00000033, 1);
    wait_idle();
    check("t6_last_data", last_data, 32'h33);

    // reset in the middle of an access with a second op queued
    push_op(1'b0, 3'b010, 32'h500, 32'h0, 5'd14, 32'h0, 0);
    push_op(1'b0, 3'b010, 32'h504, 32'h0, 5'd15, 32'h1, 1);
    repeat (2) @(posedge clk);
    #1;
    check("t7_busy_before_reset", data_enable, 1);
    flushing = 1'b1;
    exp_q.delete();
    issue_q.delete();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("t7_enable_dropped", data_enable, 0);
    check("t7_no_rsp", rsp_valid, 0);
    check("t7_fifo_empty", cpu_ready, 1);
    check("t7_state_idle", dbg_state, 0);
    @(posedge clk); #1;
    flushing = 1'b0;
    rs0 = rsp_seen;
    push_op(1'b0, 3'b010, 32'h8, 32'h0, 5'd16, 32'h13572468, 2);
    wait_idle();
    check("t7_rsp_count", rsp_seen - rs0, 1);
    check("t7_data", last_data, 32'h13572468);
    check("t7_tag", last_tag, 16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
